// File: rtl/crc32_pkg.sv
// CRC-32 (IEEE 802.3) constants, the stream-checker state type, and a bit-reflect helper.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'h2144DF1C;

    typedef enum logic {IDLE, FRAME} state_t;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // The checker shifts LSB first, so it works with the bit-reversed polynomial.
    localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational single-byte CRC-32 advance (reflected register, byte LSB first).
// No latency, no flow control; chained per byte lane by the checker.
module crc32_byte_step
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc32_stream_chk.sv
// Sniffing CRC-32 checker: crc_out/frm_len one cycle after each beat, done/crc_ok one cycle after eof; never stalls.
// Frame statistics counters exist only when CRC_STREAM_STATS_EN is defined.
module crc32_stream_chk
    import crc32_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    input  logic [DATA_W/8-1:0]   s_keep,
    input  logic                  s_sof,
    input  logic                  s_eof,
    output logic [31:0]           crc_out,
    output logic [CNT_W-1:0]      frm_len,
    output logic                  done,
    output logic                  crc_ok,
    output logic                  err_proto,
    output logic [31:0]           frame_cnt,
    output logic [31:0]           bad_cnt
);

    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB + 1);

    state_t           state;
    logic [31:0]      crc_reg;
    logic [CNT_W-1:0] len_reg;

    logic [31:0]      tap [0:NB];
    logic [LW-1:0]    n_bytes;
    logic             run;
    logic [31:0]      crc_nxt;
    logic [CNT_W-1:0] len_base;
    logic [CNT_W:0]   len_sum;
    logic [CNT_W-1:0] len_nxt;
    logic             take, drop, restart, keep_err, frm_good;

    assign take     = !clear && s_valid && (state == FRAME || s_sof);
    assign drop     = !clear && s_valid && state == IDLE && !s_sof;
    assign restart  = !clear && s_valid && state == FRAME && s_sof;
    assign keep_err = take && !s_eof && (s_keep != '1);

    assign tap[0] = s_sof ? CRC32_INIT : crc_reg;

    for (genvar g = 0; g < NB; g++) begin : g_lane
        crc32_byte_step u_step (
            .crc_in  (tap[g]),
            .data    (s_data[8*g +: 8]),
            .crc_out (tap[g+1])
        );
    end

    // Only the eof beat is trimmed; the count stops at the first disabled lane.
    always_comb begin
        n_bytes = LW'(NB);
        run     = 1'b1;
        if (s_eof) begin
            n_bytes = '0;
            for (int i = 0; i < NB; i++) begin
                if (run && s_keep[i]) n_bytes = LW'(i + 1);
                else                  run     = 1'b0;
            end
        end
    end

    assign crc_nxt  = tap[n_bytes];
    assign frm_good = ((crc_nxt ^ CRC32_XOROUT) == CRC32_RESIDUE);
    assign len_base = s_sof ? '0 : len_reg;
    assign len_sum  = {1'b0, len_base} + (CNT_W+1)'(n_bytes);
    assign len_nxt  = len_sum[CNT_W] ? '1 : len_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            crc_reg   <= CRC32_INIT;
            len_reg   <= '0;
            crc_out   <= '0;
            frm_len   <= '0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            err_proto <= drop || restart || keep_err;
            if (clear) begin
                state   <= IDLE;
                crc_reg <= CRC32_INIT;
                len_reg <= '0;
            end else if (take) begin
                crc_reg <= crc_nxt;
                len_reg <= len_nxt;
                crc_out <= crc_nxt ^ CRC32_XOROUT;
                frm_len <= len_nxt;
                if (s_eof) begin
                    state  <= IDLE;
                    done   <= 1'b1;
                    crc_ok <= frm_good;
                end else begin
                    state  <= FRAME;
                end
            end
        end
    end

`ifdef CRC_STREAM_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            bad_cnt   <= '0;
        end else if (take && s_eof) begin
            if (frame_cnt != '1)            frame_cnt <= frame_cnt + 32'd1;
            if (!frm_good && bad_cnt != '1) bad_cnt   <= bad_cnt + 32'd1;
        end
    end
`else
    assign frame_cnt = '0;
    assign bad_cnt   = '0;
`endif

endmodule
